// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encodings,
// FSM state type and the iteration count.
package muldiv_pkg;

    localparam int MULDIV_STEPS = 32;

    localparam logic [2:0] MULDIV_MUL    = 3'd0;
    localparam logic [2:0] MULDIV_MULH   = 3'd1;
    localparam logic [2:0] MULDIV_MULHSU = 3'd2;
    localparam logic [2:0] MULDIV_MULHU  = 3'd3;
    localparam logic [2:0] MULDIV_DIV    = 3'd4;
    localparam logic [2:0] MULDIV_DIVU   = 3'd5;
    localparam logic [2:0] MULDIV_REM    = 3'd6;
    localparam logic [2:0] MULDIV_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    function automatic logic op_is_div(input logic [2:0] f_op);
        return f_op[2];
    endfunction

    function automatic logic op_a_signed(input logic [2:0] f_op);
        return (f_op == MULDIV_MULH) || (f_op == MULDIV_MULHSU) ||
               (f_op == MULDIV_DIV)  || (f_op == MULDIV_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f_op);
        return (f_op == MULDIV_MULH) || (f_op == MULDIV_DIV) || (f_op == MULDIV_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath on the shared 2W-bit
// accumulator: radix-2 shift-add for multiply, restoring step for divide.
module muldiv_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      i_div,
    input  logic [2*DATA_WIDTH-1:0]   i_acc,
    input  logic [DATA_WIDTH-1:0]     i_b,
    output logic [2*DATA_WIDTH-1:0]   o_acc
);
    localparam int W = DATA_WIDTH;

    logic [W:0]   w_mul_sum;
    logic [W+1:0] w_trial;

    always_comb begin
        w_mul_sum = {1'b0, i_acc[2*W-1:W]} + (i_acc[0] ? {1'b0, i_b} : {(W+1){1'b0}});
        // shifted remainder can reach W+1 bits before the subtract
        w_trial   = {1'b0, i_acc[2*W-1:W-1]} - {2'b00, i_b};
        if (i_div) begin
            if (w_trial[W+1])
                o_acc = {i_acc[2*W-2:0], 1'b0};
            else
                o_acc = {w_trial[W-1:0], i_acc[W-2:0], 1'b1};
        end else begin
            o_acc = {w_mul_sum, i_acc[W-1:1]};
        end
    end

endmodule

// File: rtl/execute_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit for the execute stage.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier (divide unchanged).
module execute_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int OP_WIDTH       = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      kill,
    input  logic                      start,
    input  logic [OP_WIDTH-1:0]       op,
    input  logic [DATA_WIDTH-1:0]     rs1_val,
    input  logic [DATA_WIDTH-1:0]     rs2_val,
    input  logic [REG_ADDR_WIDTH-1:0] rd_in,
    output logic                      stall,
    output logic                      done,
    output logic [DATA_WIDTH-1:0]     result,
    output logic [REG_ADDR_WIDTH-1:0] rd_out
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(MULDIV_STEPS);

    muldiv_state_t             r_state;
    muldiv_state_t             w_next_state;
    logic [OP_WIDTH-1:0]       r_op;
    logic [2*W-1:0]            r_acc;
    logic [W-1:0]              r_b;
    logic                      r_neg;
    logic                      r_neg_rem;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic [CW-1:0]             r_cnt;
    logic [W-1:0]              r_result;
    logic [REG_ADDR_WIDTH-1:0] r_rd_out;

    logic           w_a_neg, w_b_neg;
    logic [W-1:0]   w_a_mag, w_b_mag;
    logic           w_div_zero, w_div_ovf, w_special;
    logic [W-1:0]   w_special_res;
    logic [W-1:0]   w_short_res;
    logic [2*W-1:0] w_step_acc;

    function automatic logic [W-1:0] finalize(input logic [OP_WIDTH-1:0] f_op,
                                              input logic [2*W-1:0]      f_acc,
                                              input logic                f_neg,
                                              input logic                f_neg_rem);
        logic [2*W-1:0] prod;
        logic [W-1:0]   quo;
        logic [W-1:0]   rem;
        prod = f_neg     ? -f_acc          : f_acc;
        quo  = f_neg     ? -f_acc[W-1:0]   : f_acc[W-1:0];
        rem  = f_neg_rem ? -f_acc[2*W-1:W] : f_acc[2*W-1:W];
        if (op_is_div(f_op))
            return f_op[1] ? rem : quo;
        else
            return (f_op == MULDIV_MUL) ? prod[W-1:0] : prod[2*W-1:W];
    endfunction

    always_comb begin
        w_a_neg    = op_a_signed(op) & rs1_val[W-1];
        w_b_neg    = op_b_signed(op) & rs2_val[W-1];
        w_a_mag    = w_a_neg ? -rs1_val : rs1_val;
        w_b_mag    = w_b_neg ? -rs2_val : rs2_val;
        w_div_zero = (rs2_val == '0);
        w_div_ovf  = op_b_signed(op) && (rs1_val == {1'b1, {(W-1){1'b0}}}) && (rs2_val == '1);
        w_special  = op_is_div(op) & (w_div_zero | w_div_ovf);
        // op[1] selects remainder
        if (w_div_zero)
            w_special_res = op[1] ? rs1_val : '1;
        else
            w_special_res = op[1] ? '0 : rs1_val;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0] w_fast_a, w_fast_b, w_fast_prod;
    always_comb begin
        w_fast_a    = {{W{op_a_signed(op) & rs1_val[W-1]}}, rs1_val};
        w_fast_b    = {{W{op_b_signed(op) & rs2_val[W-1]}}, rs2_val};
        w_fast_prod = w_fast_a * w_fast_b;
        if (op_is_div(op))
            w_short_res = w_special_res;
        else
            w_short_res = (op == MULDIV_MUL) ? w_fast_prod[W-1:0] : w_fast_prod[2*W-1:W];
    end
`else
    assign w_short_res = w_special_res;
`endif

    muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .i_div (r_state == DIV),
        .i_acc (r_acc),
        .i_b   (r_b),
        .o_acc (w_step_acc)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (op_is_div(op))
                        w_next_state = w_special ? DONE : DIV;
                    else
`ifdef MULDIV_FAST_MUL_EN
                        w_next_state = DONE;
`else
                        w_next_state = MUL;
`endif
                end
            end
            MUL, DIV: begin
                if (r_cnt == CW'(MULDIV_STEPS - 1))
                    w_next_state = DONE;
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (kill)
            w_next_state = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_op      <= '0;
            r_acc     <= '0;
            r_b       <= '0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_rd      <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_rd_out  <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (start && !kill) begin
                        r_op      <= op;
                        r_acc     <= {{W{1'b0}}, w_a_mag};
                        r_b       <= w_b_mag;
                        r_neg     <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_rd      <= rd_in;
                        r_cnt     <= '0;
                        if (w_next_state == DONE) begin
                            r_result <= w_short_res;
                            r_rd_out <= rd_in;
                        end
                    end
                end
                MUL, DIV: begin
                    r_acc <= w_step_acc;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_next_state == DONE) begin
                        r_result <= finalize(r_op, w_step_acc, r_neg, r_neg_rem);
                        r_rd_out <= r_rd;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall  = rst_n & ((start & (r_state == IDLE) & ~kill) |
                             (r_state == MUL) | (r_state == DIV));
    assign done   = (r_state == DONE);
    assign result = r_result;
    assign rd_out = r_rd_out;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Self-checking bench for execute_muldiv_unit: vector table with a result
// scoreboard, plus kill and mid-operation reset sequences.
module tb_execute_muldiv_unit;

    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
    localparam int LAT_IT = 33;
    localparam int LAT_SH = 1;
`ifdef MULDIV_FAST_MUL_EN
    localparam int LAT_MUL = 1;
`else
    localparam int LAT_MUL = 33;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        kill = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [4:0]  rd_in = '0;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];
    exp_t sb_q[$];

    execute_muldiv_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .OP_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .kill(kill), .start(start), .op(op),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
        .stall(stall), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%h required=0x%h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding op.
    always @(negedge clk) begin
        if (done === 1'b1) begin : mon
            exp_t e;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_done: actual result=0x%h rd=%0d required no done", result, rd_out);
            end else begin
                e = sb_q.pop_front();
                chk("sb_result", result, e.res);
                chk("sb_rd_out", {27'd0, rd_out}, {27'd0, e.rd});
            end
        end
    end

    function automatic void add_vec(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                    input logic [4:0] rd, input logic [31:0] exp, input int lat);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.rd = rd; v.exp = exp; v.lat = lat;
        vecs.push_back(v);
    endfunction

    // Entered just after a posedge with the DUT idle; returns just after a posedge.
    task automatic run_op(input string tag, input vec_t v);
        exp_t e;
        int   cyc;
        int   stall_cnt;
        bit   seen;
        e.res = v.exp;
        e.rd  = v.rd;
        sb_q.push_back(e);
        start = 1'b1; op = v.op; rs1_val = v.a; rs2_val = v.b; rd_in = v.rd;
        @(negedge clk);
        stall_cnt = (stall === 1'b1) ? 1 : 0;
        @(posedge clk); #1;
        start = 1'b0;
        op = 3'($urandom); rs1_val = $urandom; rs2_val = $urandom; rd_in = 5'($urandom);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) seen = 1'b1;
            else if (stall === 1'b1) stall_cnt++;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: actual no done in %0d cycles required done at %0d", tag, cyc, v.lat);
            sb_q.delete();
        end else begin
            chk({tag, "_latency"}, 32'(cyc), 32'(v.lat));
            chk({tag, "_stall_at_done"}, {31'd0, stall}, 32'd0);
        end
        chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(v.lat));
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_result_hold"}, result, v.exp);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t v;

        add_vec(OP_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 5'd1,  32'hFFFF_FFFD, LAT_IT);
        add_vec(OP_REM,    32'h0000_0007, 32'hFFFF_FFFE, 5'd2,  32'h0000_0001, LAT_IT);
        add_vec(OP_DIVU,   32'h1234_5678, 32'h0000_0000, 5'd3,  32'hFFFF_FFFF, LAT_SH);
        add_vec(OP_REMU,   32'h1234_5678, 32'h0000_0000, 5'd4,  32'h1234_5678, LAT_SH);
        add_vec(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd5,  32'h8000_0000, LAT_SH);
        add_vec(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000, LAT_SH);
        add_vec(OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd7,  32'h4000_0000, LAT_MUL);
        add_vec(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, LAT_MUL);
        add_vec(OP_MUL,    32'h0000_0003, 32'hFFFF_FFFB, 5'd9,  32'hFFFF_FFF1, LAT_MUL);
        add_vec(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFE, LAT_MUL);
        add_vec(OP_MULH,   32'hFFFF_FFFF, 32'h0000_0002, 5'd11, 32'hFFFF_FFFF, LAT_MUL);
        add_vec(OP_MUL,    32'h1234_5678, 32'h0000_0010, 5'd12, 32'h2345_6780, LAT_MUL);
        add_vec(OP_DIVU,   32'd100,       32'd7,         5'd13, 32'd14,        LAT_IT);
        add_vec(OP_REMU,   32'd100,       32'd7,         5'd14, 32'd2,         LAT_IT);
        add_vec(OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd15, 32'hFFFF_FFFD, LAT_IT);
        add_vec(OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd16, 32'hFFFF_FFFF, LAT_IT);
        add_vec(OP_DIV,    32'hFFFF_FFF9, 32'h0000_0000, 5'd17, 32'hFFFF_FFFF, LAT_SH);
        add_vec(OP_REM,    32'hFFFF_FFF9, 32'h0000_0000, 5'd18, 32'hFFFF_FFF9, LAT_SH);
        add_vec(OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h0000_0000, LAT_IT);
        add_vec(OP_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h8000_0000, LAT_IT);
        add_vec(OP_DIV,    32'h8000_0000, 32'h0000_0002, 5'd21, 32'hC000_0000, LAT_IT);

        // Reset state, with start asserted to show stall is masked.
        start = 1'b1; op = OP_DIV; rs1_val = 32'd9; rs2_val = 32'd2; rd_in = 5'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_rd_out", {27'd0, rd_out}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++)
            run_op($sformatf("v%0d", i), vecs[i]);

        // Kill a DIV at T+10, then start a new op at T+11.
        start = 1'b1; op = OP_DIV; rs1_val = 32'd1000; rs2_val = 32'd3; rd_in = 5'd25;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(negedge clk);
        chk("kill_stall_busy", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        kill = 1'b0;
        v.op = OP_DIVU; v.a = 32'd100; v.b = 32'd7; v.rd = 5'd9; v.exp = 32'd14; v.lat = LAT_IT;
        run_op("after_kill", v);

        // kill wins over start in IDLE.
        start = 1'b1; kill = 1'b1; op = OP_DIVU; rs1_val = 32'd5; rs2_val = 32'd0; rd_in = 5'd30;
        @(negedge clk);
        chk("kill_prio_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        @(negedge clk);
        chk("kill_prio_no_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;

        // Reset at T+5 of a DIV.
        start = 1'b1; op = OP_DIV; rs1_val = 32'd1000; rs2_val = 32'd3; rd_in = 5'd27;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_stall_now", {31'd0, stall}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_rd_out", {27'd0, rd_out}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        v.op = OP_MULHU; v.a = 32'h0001_0000; v.b = 32'h0001_0000; v.rd = 5'd31; v.exp = 32'd1; v.lat = LAT_MUL;
        run_op("after_reset", v);

        repeat (3) @(posedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/execute_muldiv_unit.md
# execute_muldiv_unit

Multi-cycle RV32M multiply/divide unit in the execute stage, directly downstream of the decode/execute pipeline register. It consumes operand values, destination register and funct3 for M-extension instructions. It holds the pipeline with a stall request while it computes, then presents one result-valid cycle for the writeback path.

## Interface
- DATA_WIDTH, 32, operand/result width
- REG_ADDR_WIDTH, 5, destination register index width
- OP_WIDTH, 3, operation code width (RV32M funct3)

- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low; clock clk
- kill  in  1  synchronous flush of any in-flight operation (active high)
- start  in  1  execute-stage instruction is valid and is an M-extension op
- op  in  OP_WIDTH  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_val  in  DATA_WIDTH  operand A
- rs2_val  in  DATA_WIDTH  operand B
- rd_in  in  REG_ADDR_WIDTH  destination register
- stall  out  1  hold upstream stages and the decode/execute register
- done  out  1  result valid, single-cycle pulse
- result  out  DATA_WIDTH  result, valid when done=1
- rd_out  out  REG_ADDR_WIDTH  destination register of result

## Operation
- States: IDLE, MUL, DIV, DONE.
- In IDLE, with start=1 and kill=0: latch the op, the operand magnitudes, the sign flags and rd_in.
  - Special divide cases go directly to DONE.
  - Other divides go to DIV with iteration counter = 0.
  - Multiplies go to MUL, or to DONE when fast multiply is compiled in.
- In DONE, start is ignored; the state always returns to IDLE. The instruction still presented in that cycle is the one being retired.
- Signed ops work on absolute values.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - The final sign fix is applied when entering DONE.
  - Quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
- MUL: 32 radix-2 shift-add steps into a 64-bit unsigned accumulator. The result is the low word for MUL and the high word for MULH/MULHSU/MULHU.
- DIV: 32 restoring steps. Each step shifts the remainder:dividend pair left by one bit and subtracts the divisor when the subtraction gives no borrow. Counter 0..31; on 31 go to DONE.
- Special cases (no iteration):
  - Divisor 0: quotient = 0xFFFFFFFF, remainder = rs1_val.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- stall = (start & state==IDLE & ~kill) | state==MUL | state==DIV. stall is combinational and 0 in DONE.
- kill=1 in any state: next state IDLE, done=0 next cycle, result discarded. kill takes priority over start.
- Reset (rst_n=0), including mid-operation: state IDLE, counter 0, done 0, result 0, rd_out 0. stall reads 0 while reset is asserted.

## Timing
- start accepted at cycle T (state IDLE). State is registered.
- Iterative op: DIV or MUL during cycles T+1..T+32. DONE, done=1 and result valid at T+33.
  - stall is high for cycles T..T+32, i.e. 33 cycles.
- Special divide, or fast multiply: DONE at T+1; stall is high only at T.
- done is high for exactly one cycle. result and rd_out are registered and hold their value until the next DONE or a reset.
- Earliest next accept is T+34 (iterative) or T+2 (short path).

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - Multiplies compute a 64-bit signed/unsigned product in one cycle and go IDLE→DONE.
  - The MUL state is unreachable.
- Not defined: the iterative 32-step multiply described above.
- Divide behaviour is identical in both builds.

## Structure
- Shared package muldiv_pkg holds:
  - the op encoding constants (MULDIV_MUL … MULDIV_REMU),
  - the state enum type muldiv_state_t,
  - the iteration count constant MULDIV_STEPS = 32.
- One sub-module, muldiv_step: the combinational single-iteration datapath (shift-add for multiply, shift-compare-subtract for divide). It is instantiated once and selected by the current state.

## Test plan
- DIV rs1=7, rs2=0xFFFFFFFE at T → stall high for T..T+32, done at T+33, result=0xFFFFFFFD; REM on the same operands → result=1.
- DIVU 0x12345678 / 0 → done at T+1, result=0xFFFFFFFF; REMU 0x12345678 / 0 → result=0x12345678.
- DIV 0x80000000 / 0xFFFFFFFF → result=0x80000000 at T+1; REM on the same operands → 0.
- Multiply checks:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - MUL 3 × 0xFFFFFFFB → 0xFFFFFFF1.
  - done at T+33 without MULDIV_FAST_MUL_EN, at T+1 with it.
- kill at T+10 of a DIV → IDLE at T+11, done never asserts, a new start at T+11 is accepted with correct rd_out.
- rst_n=0 at T+5 of a DIV → all outputs 0 next cycle, stall 0, state IDLE.
